// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 8 data bits LSB first, optional even parity, one stop bit.
// Each bit is the 2-of-3 majority of mid-bit samples; results are reported as single-clk pulses.
module uart_rx #(
    parameter bit PARITY_EN = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_en,
    input  logic [2:0] baud_set,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    // state  | meaning
    // IDLE   | waiting for a falling edge on the synchronized line
    // START  | checking the start bit, false starts fall back to IDLE
    // DATA   | shifting in 8 data bits, LSB first
    // PARITY | sampling the even-parity bit (PARITY_EN=1 only)
    // STOP   | sampling the stop bit, result decided mid-bit
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync, rx_hist;
    logic [2:0]  baud_lat;
    logic [8:0]  div_cnt, term;
    logic [3:0]  sidx;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        smp7, smp8, par_bad;
    logic        fall, tick, maj, at_idx9, at_wrap;
    logic        done_nxt, ferr_nxt, perr_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_hist <= rx_sync;
        end
    end

    assign fall = rx_hist & ~rx_sync;

    always_comb begin
        term = 9'd325;
        case (baud_lat)
            3'd1:    term = 9'd162;
            3'd2:    term = 9'd80;
            3'd3:    term = 9'd53;
            3'd4:    term = 9'd26;
            default: term = 9'd325;
        endcase
    end

    assign tick    = (state != IDLE) && (div_cnt == term);
    assign at_idx9 = tick && (sidx == 4'd9);
    assign at_wrap = tick && (sidx == 4'd15);
    // index-9 sample is taken straight from the line, the other two were stored earlier
    assign maj     = (smp7 & smp8) | (smp7 & rx_sync) | (smp8 & rx_sync);
    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
        perr_nxt  = 1'b0;
        if (!rx_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fall) state_nxt = START;
                end
                START: begin
                    if (at_idx9 && maj) state_nxt = IDLE;
                    else if (at_wrap)   state_nxt = DATA;
                end
                DATA: begin
                    if (at_wrap && (bit_cnt == 3'd7))
                        state_nxt = PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    if (at_wrap) state_nxt = STOP;
                end
                STOP: begin
                    if (at_idx9) begin
                        state_nxt = IDLE;
                        done_nxt  = maj & ~(PARITY_EN & par_bad);
                        ferr_nxt  = ~maj;
                        perr_nxt  = PARITY_EN & par_bad;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_lat <= 3'd0;
            div_cnt  <= 9'd0;
            sidx     <= 4'd0;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'h00;
            smp7     <= 1'b1;
            smp8     <= 1'b1;
            par_bad  <= 1'b0;
        end else if (!rx_en || (state == IDLE)) begin
            div_cnt <= 9'd0;
            sidx    <= 4'd0;
            bit_cnt <= 3'd0;
            if (rx_en && fall) begin
                baud_lat <= baud_set;
                par_bad  <= 1'b0;
            end
        end else if (tick) begin
            div_cnt <= 9'd0;
            sidx    <= sidx + 4'd1;
            if (sidx == 4'd7) smp7 <= rx_sync;
            if (sidx == 4'd8) smp8 <= rx_sync;
            if ((state == DATA) && (sidx == 4'd9))   shift_q <= {maj, shift_q[7:1]};
            if ((state == DATA) && (sidx == 4'd15))  bit_cnt <= bit_cnt + 3'd1;
            if ((state == PARITY) && (sidx == 4'd9)) par_bad <= (^shift_q) ^ maj;
        end else begin
            div_cnt <= div_cnt + 9'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_byte  <= 8'h00;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_done    <= done_nxt;
            frame_err  <= ferr_nxt;
            parity_err <= perr_nxt;
            if (done_nxt) data_byte <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance without parity, one with even parity, sharing the serial line.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n, rx_en, rx;
    logic [2:0] baud_set;
    logic [7:0] data_byte0, data_byte1;
    logic       rx_done0, frame_err0, parity_err0, rx_busy0;
    logic       rx_done1, frame_err1, parity_err1, rx_busy1;

    uart_rx #(.PARITY_EN(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .baud_set(baud_set), .rx(rx),
        .data_byte(data_byte0), .rx_done(rx_done0), .frame_err(frame_err0),
        .parity_err(parity_err0), .rx_busy(rx_busy0)
    );

    uart_rx #(.PARITY_EN(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx_en(rx_en), .baud_set(baud_set), .rx(rx),
        .data_byte(data_byte1), .rx_done(rx_done1), .frame_err(frame_err1),
        .parity_err(parity_err1), .rx_busy(rx_busy1)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    int done_cyc = 0;
    int n_done0 = 0, n_ferr0 = 0, n_perr0 = 0;
    int n_done1 = 0, n_ferr1 = 0, n_perr1 = 0, n_both1 = 0;
    logic [7:0] last_byte0 = 8'h00, prev_byte0 = 8'h00;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done0) begin
            n_done0    <= n_done0 + 1;
            done_cyc   <= cyc;
            prev_byte0 <= last_byte0;
            last_byte0 <= data_byte0;
        end
        if (frame_err0)  n_ferr0 <= n_ferr0 + 1;
        if (parity_err0) n_perr0 <= n_perr0 + 1;
        if (rx_done1)    n_done1 <= n_done1 + 1;
        if (frame_err1)  n_ferr1 <= n_ferr1 + 1;
        if (parity_err1) n_perr1 <= n_perr1 + 1;
        if (frame_err1 && parity_err1) n_both1 <= n_both1 + 1;
    end

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int got, input int lo, input int hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d..%0d", nm, got, lo, hi);
        end
    endtask

    // abort: 0 none, 1 reset pulse, 2 rx_en drop, both applied 100 clk into data bit 3
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit use_par, input bit par,
                              input int bclk, input bit chg, input int abort);
        rx = 1'b0;
        t0 = cyc;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (chg && i == 2) baud_set = 3'd0;
            if (abort != 0 && i == 3) begin
                repeat (100) @(negedge clk);
                if (abort == 1) reset_n = 1'b0;
                else            rx_en = 1'b0;
                repeat (3) @(negedge clk);
                chk("abort_busy", 32'(rx_busy0), 32'd0);
                chk("abort_done", 32'(rx_done0), 32'd0);
                reset_n = 1'b1;
                rx_en   = 1'b1;
                repeat (bclk - 103) @(negedge clk);
            end else begin
                repeat (bclk) @(negedge clk);
            end
        end
        if (use_par) begin
            rx = par;
            repeat (bclk) @(negedge clk);
        end
        rx = stop;
        repeat (bclk) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic par_case(input logic [7:0] d, input bit par, input bit stop, input int e_done,
                            input int e_ferr, input int e_perr, input int e_both, input logic [7:0] e_byte);
        int b_done, b_ferr, b_perr, b_both;
        b_done = n_done1; b_ferr = n_ferr1; b_perr = n_perr1; b_both = n_both1;
        send_frame(d, stop, 1'b1, par, 434, 1'b0, 0);
        repeat (100) @(negedge clk);
        chk("par_done", 32'(n_done1 - b_done), 32'(e_done));
        chk("par_ferr", 32'(n_ferr1 - b_ferr), 32'(e_ferr));
        chk("par_perr", 32'(n_perr1 - b_perr), 32'(e_perr));
        chk("par_both", 32'(n_both1 - b_both), 32'(e_both));
        chk("par_byte", 32'(data_byte1), 32'(e_byte));
    endtask

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         chg;
        int         e_done;
        int         e_ferr;
        logic [7:0] e_byte;
    } vec_t;

    vec_t vt[6];

    initial begin
        int b_done, b_ferr;
        vt[0] = '{8'hA5, 1'b1, 1'b0, 1, 0, 8'hA5};
        vt[1] = '{8'h3C, 1'b0, 1'b0, 0, 1, 8'hA5};
        vt[2] = '{8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A};
        vt[3] = '{8'h81, 1'b1, 1'b0, 1, 0, 8'h81};
        vt[4] = '{8'h00, 1'b0, 1'b0, 0, 1, 8'h81};
        vt[5] = '{8'hFF, 1'b1, 1'b0, 1, 0, 8'hFF};

        rx = 1'b1; rx_en = 1'b1; baud_set = 3'd4; reset_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_byte0", 32'(data_byte0), 32'h00);
        chk("rst_byte1", 32'(data_byte1), 32'h00);
        chk("rst_busy", 32'(rx_busy0), 32'd0);
        chk("rst_done", 32'(rx_done0), 32'd0);
        chk("rst_ferr", 32'(frame_err0), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            baud_set = 3'd4;
            b_done = n_done0; b_ferr = n_ferr0;
            send_frame(vt[i].d, vt[i].stop, 1'b0, 1'b0, 434, vt[i].chg, 0);
            repeat (100) @(negedge clk);
            chk("vec_done", 32'(n_done0 - b_done), 32'(vt[i].e_done));
            chk("vec_ferr", 32'(n_ferr0 - b_ferr), 32'(vt[i].e_ferr));
            chk("vec_byte", 32'(data_byte0), 32'(vt[i].e_byte));
            chk("vec_busy", 32'(rx_busy0), 32'd0);
            if (i == 0) chk_range("latency", done_cyc - t0, 4155, 4161);
        end

        baud_set = 3'd3;
        b_done = n_done0;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 868, 1'b0, 0);
        repeat (200) @(negedge clk);
        chk("b57600_done", 32'(n_done0 - b_done), 32'd1);
        chk("b57600_byte", 32'(data_byte0), 32'hC3);

        baud_set = 3'd4;
        b_done = n_done0; b_ferr = n_ferr0;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        chk("glitch_busy_in", 32'(rx_busy0), 32'd1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_busy", 32'(rx_busy0), 32'd0);
        chk("glitch_done", 32'(n_done0 - b_done), 32'd0);
        chk("glitch_ferr", 32'(n_ferr0 - b_ferr), 32'd0);
        chk("glitch_byte", 32'(data_byte0), 32'hC3);

        b_done = n_done0; b_ferr = n_ferr0;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 434, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 434, 1'b0, 0);
        repeat (100) @(negedge clk);
        chk("b2b_done", 32'(n_done0 - b_done), 32'd2);
        chk("b2b_ferr", 32'(n_ferr0 - b_ferr), 32'd0);
        chk("b2b_first", 32'(prev_byte0), 32'h00);
        chk("b2b_second", 32'(last_byte0), 32'hFF);

        pulse_reset();
        par_case(8'h81, 1'b1, 1'b1, 0, 0, 1, 0, 8'h00);
        par_case(8'h81, 1'b0, 1'b1, 1, 0, 0, 0, 8'h81);
        par_case(8'h7E, 1'b1, 1'b0, 0, 1, 1, 1, 8'h81);
        par_case(8'h07, 1'b1, 1'b1, 1, 0, 0, 0, 8'h07);

        pulse_reset();
        repeat (20) @(negedge clk);
        b_done = n_done0; b_ferr = n_ferr0;
        send_frame(8'hF8, 1'b1, 1'b0, 1'b0, 434, 1'b0, 1);
        repeat (100) @(negedge clk);
        chk("rstab_done", 32'(n_done0 - b_done), 32'd0);
        chk("rstab_ferr", 32'(n_ferr0 - b_ferr), 32'd0);
        chk("rstab_byte", 32'(data_byte0), 32'h00);
        chk("rstab_busy", 32'(rx_busy0), 32'd0);

        send_frame(8'hF8, 1'b1, 1'b0, 1'b0, 434, 1'b0, 2);
        repeat (100) @(negedge clk);
        chk("enab_done", 32'(n_done0 - b_done), 32'd0);
        chk("enab_ferr", 32'(n_ferr0 - b_ferr), 32'd0);
        chk("enab_byte", 32'(data_byte0), 32'h00);

        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 434, 1'b0, 0);
        repeat (100) @(negedge clk);
        chk("after_done", 32'(n_done0 - b_done), 32'd1);
        chk("after_ferr", 32'(n_ferr0 - b_ferr), 32'd0);
        chk("after_byte", 32'(data_byte0), 32'h5A);
        chk("perr0_tied", 32'(n_perr0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter PARITY_EN, default 0, meaning 1 = one even-parity bit expected between data and stop.
REQ-002 SHALL have port clk  input  1  system clock (50 MHz), single clock domain.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_en  input  1  receive enable; low holds block idle.
REQ-005 SHALL have port baud_set  input  3  baud select.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port data_byte  output  8  last correctly received byte.
REQ-008 SHALL have port rx_done  output  1  one-clk pulse when data_byte is updated.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse when the stop bit is sampled 0.
REQ-010 SHALL have port parity_err  output  1  one-clk pulse on parity mismatch (PARITY_EN=1 only, else tied 0).
REQ-011 SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer plus one history flop; falling edge = history 1, synced 0.
REQ-013 SHALL generate a 16x-baud tick enable, not a derived clock, with terminal counts: baud_set 0:325 (9600), 1:162 (19200), 2:80 (38400), 3:53 (57600), 4:26 (115200), 5-7:325.
REQ-014 SHALL latch baud_set at start detection; baud_set changes mid-frame SHALL have no effect until the next frame.
REQ-015 SHALL clear the divider and sample index on start detection, so the first tick occurs terminal+1 clks later.
REQ-016 SHALL run states IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
REQ-017 SHALL count sample index 0..15 per bit on ticks; index wrap 15->0 ends a bit period.
REQ-018 SHALL sample synced rx at indices 7, 8 and 9 and take the bit value as the 2-of-3 majority, decided on the index-9 tick.
REQ-019 SHALL return START -> IDLE (false start, no output pulse) if the START majority is 1.
REQ-020 SHALL shift DATA bits LSB first, 8 bits, using a 3-bit bit counter.
REQ-021 SHALL, in PARITY, flag a mismatch if the XOR of the 8 data bits and the parity bit is not 0.
REQ-022 SHALL, on the STOP index-9 decision, go directly to IDLE, so a new start edge is accepted from the next clk onward.
REQ-023 SHALL, when STOP=1 and there is no parity error, load data_byte and pulse rx_done for exactly 1 clk.
REQ-024 SHALL, when STOP=0, pulse frame_err and leave data_byte unchanged, with no rx_done; a parity error SHALL behave the same way, pulsing parity_err.
REQ-025 SHALL pulse frame_err and parity_err together (with no rx_done) when both errors occur.
REQ-026 SHALL ignore falling edges outside IDLE.
REQ-027 SHALL, when rx_en=0, force IDLE, clear the divider and counters, suppress all pulses, abort any partial frame with no output, and keep data_byte unchanged.

Reset
REQ-028 SHALL, on reset_n low, asynchronously reset: state IDLE, data_byte 0x00, rx_done/frame_err/parity_err/rx_busy 0, synchronizer and history flops 1, divider, sample and bit counters 0.
REQ-029 SHALL abort a frame in progress on reset, with no pulse after release.
REQ-030 SHALL, on release of reset with rx held low, not detect a start until a falling edge is seen.

Verification
REQ-031 SHALL be verified by: baud_set=4, PARITY_EN=0, frame 0xA5 at 434 clk/bit -> single rx_done ~4158±3 clk after the start edge, data_byte=0xA5, rx_busy low afterwards.
REQ-032 SHALL be verified by: low glitch of 100 clk at baud_set=4 -> return to IDLE, no rx_done or frame_err, data_byte unchanged.
REQ-033 SHALL be verified by: frame 0x3C with stop bit 0 -> frame_err pulse, no rx_done, data_byte keeps its previous value.
REQ-034 SHALL be verified by: back-to-back 0x00 then 0xFF with zero idle between stop and next start -> two rx_done pulses with data_byte 0x00 then 0xFF.
REQ-035 SHALL be verified by: PARITY_EN=1, 0x81 sent with parity bit 1 -> parity_err pulse, no rx_done; resent with parity bit 0 -> rx_done, data_byte 0x81.
REQ-036 SHALL be verified by: rx_en dropped, or reset_n pulsed, during bit 3 of a frame -> immediate IDLE, no pulses; the next full frame 0x5A is received correctly.
